// File: rtl/pulso_sched_if.sv
// pulso_sched_if: request/grant/timer bundle between requesters and the pulso_sched timer.
// The requester side drives Req/Dly/Cancel; the scheduler returns grant, completion and count.
interface pulso_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 18
);
    logic [NREQ-1:0]    Req;
    logic [NREQ*CW-1:0] Dly;
    logic               Cancel;
    logic [NREQ-1:0]    Gnt;
    logic [NREQ-1:0]    Ack;
    logic               Mo;
    logic               Busy;
    logic [CW-1:0]      Cnt;

    modport master (
        output Req, Dly, Cancel,
        input  Gnt, Ack, Mo, Busy, Cnt
    );

    modport slave (
        input  Req, Dly, Cancel,
        output Gnt, Ack, Mo, Busy, Cnt
    );
endinterface

// File: rtl/pulso_sched.sv
// pulso_sched: NREQ requesters share one down-counter; winner's delay is counted out, then Ack/Mo pulse.
// Define PULSO_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module pulso_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CW   = 18
) (
    input  logic         Clk,
    input  logic         Clr_n,
    pulso_sched_if.slave bus
);
    localparam int unsigned     IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] OneHot0 = NREQ'(1);
    localparam logic [CW-1:0]   CntOne  = CW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [NREQ-1:0] r_ack, w_ack_nxt;
    logic [IW-1:0]   r_win, w_win_nxt;
    logic            r_mo, r_busy, r_rst_ok;
    logic [IW-1:0]   w_pick, w_idx;
    logic            w_found;
    logic [CW-1:0]   w_dly;
`ifdef PULSO_SCHED_RR_EN
    logic [IW-1:0]   r_last, w_last_nxt;
`endif

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
`ifdef PULSO_SCHED_RR_EN
            w_idx = IW'((32'(r_last) + 32'd1 + k) % NREQ);
`else
            w_idx = IW'(k);
`endif
            if (!w_found && bus.Req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_dly = CW'(bus.Dly >> (32'(w_pick) * CW));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_ack_nxt   = '0;
        w_win_nxt   = r_win;
`ifdef PULSO_SCHED_RR_EN
        w_last_nxt  = r_last;
`endif
        unique case (r_state)
            StIdle: begin
                // r_rst_ok holds off the first edge after reset release
                if (r_rst_ok && w_found) begin
                    w_state_nxt = StRun;
                    w_gnt_nxt   = OneHot0 << w_pick;
                    w_win_nxt   = w_pick;
                    w_cnt_nxt   = (w_dly == '0) ? CntOne : w_dly;
                end
            end
            StRun: begin
                if (bus.Cancel || !bus.Req[r_win]) begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
`ifdef PULSO_SCHED_RR_EN
                    w_last_nxt  = r_win;
`endif
                end else if (r_cnt == CntOne) begin
                    w_state_nxt = StDone;
                    w_gnt_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_ack_nxt   = OneHot0 << r_win;
`ifdef PULSO_SCHED_RR_EN
                    w_last_nxt  = r_win;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - CntOne;
                end
            end
            StDone: w_state_nxt = StIdle;
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
            r_win    <= '0;
            r_mo     <= 1'b0;
            r_busy   <= 1'b0;
            r_rst_ok <= 1'b0;
`ifdef PULSO_SCHED_RR_EN
            r_last   <= IW'(NREQ - 1);
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_gnt    <= w_gnt_nxt;
            r_ack    <= w_ack_nxt;
            r_win    <= w_win_nxt;
            r_mo     <= |w_ack_nxt;
            r_busy   <= (w_state_nxt != StIdle);
            r_rst_ok <= 1'b1;
`ifdef PULSO_SCHED_RR_EN
            r_last   <= w_last_nxt;
`endif
        end
    end

    assign bus.Gnt  = r_gnt;
    assign bus.Ack  = r_ack;
    assign bus.Mo   = r_mo;
    assign bus.Busy = r_busy;
    assign bus.Cnt  = r_cnt;
endmodule

// File: tb/tb_pulso_sched.sv
// tb_pulso_sched: directed scenarios then random traffic, every cycle checked against
// a transaction-level model of the scheduler.
module tb_pulso_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned CW   = 18;

    logic Clk   = 1'b0;
    logic Clr_n = 1'b1;

    pulso_sched_if #(.NREQ(NREQ), .CW(CW)) bus ();

    pulso_sched #(.NREQ(NREQ), .CW(CW)) dut (
        .Clk   (Clk),
        .Clr_n (Clr_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 counting, 2 completion cycle
    int m_phase, m_owner, m_left, m_ack;
    bit m_armed;
`ifdef PULSO_SCHED_RR_EN
    int m_last;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] r);
        int start;
        start = 0;
`ifdef PULSO_SCHED_RR_EN
        start = (m_last + 1) % NREQ;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (((r >> ((start + k) % NREQ)) & NREQ'(1)) != '0) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = -1;
        m_left  = 0;
        m_ack   = -1;
        m_armed = 1'b0;
`ifdef PULSO_SCHED_RR_EN
        m_last  = NREQ - 1;
`endif
    endtask

    task automatic model_edge();
        logic [NREQ-1:0] r;
        int d;
        r = bus.Req;
        if (!Clr_n) begin
            model_reset();
            return;
        end
        m_ack = -1;
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            if (bus.Cancel || ((r >> m_owner) & NREQ'(1)) == '0) begin
`ifdef PULSO_SCHED_RR_EN
                m_last = m_owner;
`endif
                m_owner = -1;
                m_left  = 0;
                m_phase = 0;
            end else if (m_left == 1) begin
`ifdef PULSO_SCHED_RR_EN
                m_last = m_owner;
`endif
                m_ack   = m_owner;
                m_owner = -1;
                m_left  = 0;
                m_phase = 2;
            end else begin
                m_left--;
            end
        end else if (m_armed && r != '0) begin
            m_owner = pick(r);
            d       = int'(CW'(bus.Dly >> (m_owner * CW)));
            m_left  = (d == 0) ? 1 : d;
            m_phase = 1;
        end
        m_armed = 1'b1;
    endtask

    task automatic check_all(input string tag);
        logic [NREQ-1:0] eg, ea;
        eg = (m_phase == 1) ? (NREQ'(1) << m_owner) : '0;
        ea = (m_ack >= 0) ? (NREQ'(1) << m_ack) : '0;
        chk({tag, ".gnt"}, 32'(bus.Gnt), 32'(eg));
        chk({tag, ".ack"}, 32'(bus.Ack), 32'(ea));
        chk({tag, ".mo"}, 32'(bus.Mo), (m_ack >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".busy"}, 32'(bus.Busy), (m_phase != 0) ? 32'd1 : 32'd0);
        chk({tag, ".cnt"}, 32'(bus.Cnt), 32'(m_left));
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic set_dly(input int i, input int v);
        logic [NREQ*CW-1:0] m;
        m       = {{(NREQ*CW-CW){1'b0}}, {CW{1'b1}}} << (i * CW);
        bus.Dly = (bus.Dly & ~m) | ((NREQ*CW)'(CW'(v)) << (i * CW));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] exp_order [5];
        logic [NREQ-1:0] got_order [5];
        logic [NREQ-1:0] prev_gnt, bitm;
        int got;

        bus.Req = '0;
        bus.Dly = '0;
        bus.Cancel = 1'b0;
        model_reset();

        // Reset must act without a clock edge
        #2 Clr_n = 1'b0;
        #1 check_all("reset");
        step("rst_hold");
        step("rst_hold");
        #3 Clr_n = 1'b1;
        step("rel1");
        step("rel2");

        // Single request, delay 5
        bus.Req = 4'b0001;
        set_dly(0, 5);
        for (int n = 1; n <= 7; n++) begin
            step("single");
            if (n == 1) begin
                chk("single.gnt_e1", 32'(bus.Gnt), 32'h1);
                chk("single.cnt_e1", 32'(bus.Cnt), 32'd5);
            end
            if (n == 6) begin
                chk("single.ack_e6", 32'(bus.Ack), 32'h1);
                chk("single.mo_e6", 32'(bus.Mo), 32'd1);
                bus.Req = '0;
            end
            if (n == 7) chk("single.busy_e7", 32'(bus.Busy), 32'd0);
        end

        // Zero delay loads 1
        bus.Req = 4'b0100;
        set_dly(2, 0);
        step("zero");
        chk("zero.cnt", 32'(bus.Cnt), 32'd1);
        step("zero");
        chk("zero.ack", 32'(bus.Ack), 32'h4);
        bus.Req = '0;
        step("zero");
        step("zero");

        // Contention, all delays 3
`ifdef PULSO_SCHED_RR_EN
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int i = 0; i < NREQ; i++) set_dly(i, 3);
        bus.Req  = 4'b1111;
        got      = 0;
        prev_gnt = '0;
        for (int n = 0; n < 60 && got < 5; n++) begin
            step("contend");
            if (bus.Gnt != '0 && prev_gnt == '0) begin
                got_order[got] = bus.Gnt;
                got++;
            end
            prev_gnt = bus.Gnt;
            if (m_ack >= 0) bus.Req = 4'b1111 & ~(NREQ'(1) << m_ack);
            else bus.Req = 4'b1111;
        end
        chk("contend.count", 32'(got), 32'd5);
        for (int i = 0; i < 5; i++) chk("contend.order", 32'(got_order[i]), 32'(exp_order[i]));
        bus.Req = '0;
        for (int n = 0; n < 6; n++) step("contend_drain");

        // Cancel at Cnt=4
        bus.Req = 4'b0010;
        set_dly(1, 10);
        for (int n = 0; n < 20; n++) begin
            step("cancel_run");
            if (m_phase == 1 && m_left == 4) break;
        end
        chk("cancel.cnt4", 32'(bus.Cnt), 32'd4);
        bus.Cancel = 1'b1;
        step("cancel");
        chk("cancel.gnt", 32'(bus.Gnt), 32'h0);
        chk("cancel.cnt", 32'(bus.Cnt), 32'd0);
        bus.Cancel = 1'b0;
        bus.Req = 4'b0011;
        step("cancel_next");
        chk("cancel.next_gnt", 32'(bus.Gnt), 32'h1);
        bus.Req = '0;
        step("cancel_drain");
        step("cancel_drain");

        // Withdrawal colliding with expiry
        bus.Req = 4'b1000;
        set_dly(3, 3);
        for (int n = 0; n < 10; n++) begin
            step("wd_run");
            if (m_phase == 1 && m_left == 1) break;
        end
        chk("wd.cnt1", 32'(bus.Cnt), 32'd1);
        bus.Req = '0;
        step("wd");
        chk("wd.ack", 32'(bus.Ack), 32'h0);
        chk("wd.busy", 32'(bus.Busy), 32'd0);
        step("wd");
        chk("wd.mo", 32'(bus.Mo), 32'd0);

        // Async reset mid-run at Cnt=7
        bus.Req = 4'b0010;
        set_dly(1, 10);
        for (int n = 0; n < 20; n++) begin
            step("ares_run");
            if (m_phase == 1 && m_left == 7) break;
        end
        chk("ares.cnt7", 32'(bus.Cnt), 32'd7);
        #2 Clr_n = 1'b0;
        model_reset();
        #1 check_all("ares");
        chk("ares.gnt_now", 32'(bus.Gnt), 32'h0);
        step("ares_hold");
        #3 Clr_n = 1'b1;
        step("ares_rel1");
        chk("ares.rel1_gnt", 32'(bus.Gnt), 32'h0);
        step("ares_rel2");
        chk("ares.rel2_gnt", 32'(bus.Gnt), 32'h2);
        bus.Req = '0;
        step("ares_drain");
        step("ares_drain");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                bitm = NREQ'(1) << i;
                if (m_ack == i) begin
                    bus.Req = bus.Req & ~bitm;
                end else if ((bus.Req & bitm) == '0) begin
                    if ($urandom_range(3) == 0) begin
                        bus.Req = bus.Req | bitm;
                        set_dly(i, ($urandom_range(9) == 0) ? int'($urandom_range(40)) :
                                   int'($urandom_range(6)));
                    end
                end else if ($urandom_range(39) == 0) begin
                    bus.Req = bus.Req & ~bitm;
                end
                if ($urandom_range(7) == 0) set_dly(i, int'($urandom_range(12)));
            end
            bus.Cancel = ($urandom_range(11) == 0);
            step("rand");
        end
        bus.Req = '0;
        bus.Cancel = 1'b0;
        for (int n = 0; n < 4; n++) step("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
